apb_slave_regfile: RTL and testbench



---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_wait_cnt.sv | 49 ++++
 rtl/apb_slave_regfile.sv | 147 ++++++++++++++
 tb/tb_apb_slave_regfile.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM encodings, address alignment and
// response codes common to completers and the master BFM.
package apb_pkg;

    typedef enum logic {
        APB_S_IDLE   = 1'b0,
        APB_S_ACCESS = 1'b1
    } apb_state_e;

    localparam int   APB_ADDR_LSB    = 2;
    localparam logic APB_RESP_OKAY   = 1'b0;
    localparam logic APB_RESP_SLVERR = 1'b1;

endpackage

// File: rtl/apb_wait_cnt.sv
// Wait-state down-counter producing a registered PREADY for APB completers.
// rdy_d_o exposes the next-cycle PREADY so read data can be aligned to it.
module apb_wait_cnt #(
    parameter int WAIT_CYC = 0
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic load_i,
    input  logic dec_i,
    input  logic clr_i,
    output logic rdy_o,
    output logic rdy_d_o
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

    logic [3:0] cnt_q, cnt_d;
    logic       rdy_q, rdy_d;

    always_comb begin
        cnt_d = cnt_q;
        rdy_d = rdy_q;
        if (clr_i) begin
            cnt_d = '0;
            rdy_d = 1'b0;
        end else if (load_i) begin
            cnt_d = WAIT_INIT;
            rdy_d = (WAIT_CYC == 0);
        end else if (dec_i && !rdy_q && cnt_q != '0) begin
            // last wait cycle: raise PREADY for the following cycle
            cnt_d = cnt_q - 4'd1;
            rdy_d = (cnt_q == 4'd1);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_q <= '0;
            rdy_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            rdy_q <= rdy_d;
        end
    end

    assign rdy_o   = rdy_q;
    assign rdy_d_o = rdy_d;

endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 completer in front of a word-addressed register bank.
// Register 0 is a read-only ID; contents and write strobes are exported.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int                ADR_W    = 32,
    parameter int                DAT_W    = 32,
    parameter int                NUM_REGS = 16,
    parameter int                WAIT_CYC = 0,
    parameter logic [DAT_W-1:0]  ID_VAL   = 32'hA5B0_0001
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    input  logic [ADR_W-1:0]          PADDR,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    input  logic                      PWRITE,
    input  logic [DAT_W-1:0]          PWDATA,
    output logic                      PREADY,
    output logic [DAT_W-1:0]          PRDATA,
    output logic                      PSLVERR,
    output logic [NUM_REGS*DAT_W-1:0] regs_o,
    output logic [NUM_REGS-1:0]       wr_pulse_o
);

    localparam int               IDX_W    = $clog2(NUM_REGS);
    localparam logic [ADR_W-1:0] ADDR_END = ADR_W'(NUM_REGS * 4);

    apb_state_e           state_q, state_d;
    logic                 write_q, write_d;
    logic                 err_q, err_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DAT_W-1:0]     regs_q [NUM_REGS];
    logic [DAT_W-1:0]     regs_d [NUM_REGS];
    logic [DAT_W-1:0]     prdata_q, prdata_d;
    logic                 pslverr_q, pslverr_d;
    logic [NUM_REGS-1:0]  wr_pulse_q, wr_pulse_d;

    logic [DAT_W-1:0]     rd_view [NUM_REGS];
    logic [IDX_W-1:0]     pidx, rd_idx;
    logic                 setup, active, complete, abort;
    logic                 err_set, rd_err, rd_wr;
    logic                 rdy_q, rdy_d;

    assign pidx     = PADDR[IDX_W+APB_ADDR_LSB-1:APB_ADDR_LSB];
    assign setup    = (state_q == APB_S_IDLE) && PSEL && !PENABLE;
    assign active   = (state_q == APB_S_ACCESS) && PSEL && PENABLE;
    assign complete = active && rdy_q;
    assign abort    = (state_q == APB_S_ACCESS) && !PSEL;
    assign err_set  = (PADDR[APB_ADDR_LSB-1:0] != '0)
                   || (PADDR >= ADDR_END)
                   || (PWRITE && pidx == '0);

    apb_wait_cnt #(
        .WAIT_CYC (WAIT_CYC)
    ) u_wait (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .load_i  (setup),
        .dec_i   (active),
        .clr_i   (complete || abort),
        .rdy_o   (rdy_q),
        .rdy_d_o (rdy_d)
    );

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_view[i] = (i == 0) ? ID_VAL : regs_q[i];
        end
    end

    // with zero wait states the response is built in the setup cycle itself
    assign rd_idx = (state_q == APB_S_IDLE) ? pidx    : idx_q;
    assign rd_err = (state_q == APB_S_IDLE) ? err_set : err_q;
    assign rd_wr  = (state_q == APB_S_IDLE) ? PWRITE  : write_q;

    always_comb begin
        state_d    = state_q;
        write_d    = write_q;
        err_d      = err_q;
        idx_d      = idx_q;
        regs_d     = regs_q;
        wr_pulse_d = '0;
        prdata_d   = '0;
        pslverr_d  = APB_RESP_OKAY;
        unique case (state_q)
            APB_S_IDLE: begin
                if (setup) begin
                    state_d = APB_S_ACCESS;
                    write_d = PWRITE;
                    err_d   = err_set;
                    idx_d   = pidx;
                end
            end
            APB_S_ACCESS: begin
                if (abort || complete) begin
                    state_d = APB_S_IDLE;
                end
                if (complete && write_q && !err_q) begin
                    regs_d[idx_q]     = PWDATA;
                    wr_pulse_d[idx_q] = 1'b1;
                end
            end
            default: state_d = APB_S_IDLE;
        endcase
        if (rdy_d) begin
            pslverr_d = rd_err ? APB_RESP_SLVERR : APB_RESP_OKAY;
            if (!rd_err && !rd_wr) begin
                prdata_d = rd_view[rd_idx];
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= APB_S_IDLE;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            prdata_q   <= '0;
            pslverr_q  <= APB_RESP_OKAY;
            wr_pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            write_q    <= write_d;
            err_q      <= err_d;
            idx_q      <= idx_d;
            prdata_q   <= prdata_d;
            pslverr_q  <= pslverr_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
        assign regs_o[g*DAT_W +: DAT_W] = rd_view[g];
    end

    assign PREADY     = rdy_q;
    assign PRDATA     = prdata_q;
    assign PSLVERR    = pslverr_q;
    assign wr_pulse_o = wr_pulse_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: three instances with 0, 2 and 3 wait states
// share one APB bus and are told apart by their PSEL lines.
module tb_apb_slave_regfile;

    localparam logic [31:0] ID = 32'hA5B0_0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] paddr, pwdata;
    logic        penable, pwrite;
    logic        psel    [3];
    logic        pready  [3];
    logic [31:0] prdata  [3];
    logic        pslverr [3];
    logic [511:0] regs   [3];
    logic [15:0] pulse   [3];

    logic [31:0] model [3][16];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        apb_slave_regfile #(
            .WAIT_CYC ((g == 0) ? 0 : ((g == 1) ? 2 : 3))
        ) u_dut (
            .PCLK       (clk),
            .PRESETn    (rst_n),
            .PADDR      (paddr),
            .PSEL       (psel[g]),
            .PENABLE    (penable),
            .PWRITE     (pwrite),
            .PWDATA     (pwdata),
            .PREADY     (pready[g]),
            .PRDATA     (prdata[g]),
            .PSLVERR    (pslverr[g]),
            .regs_o     (regs[g]),
            .wr_pulse_o (pulse[g])
        );
    end

    typedef struct {
        int          d;
        logic [31:0] rdata;
        logic        err;
    } sb_t;

    typedef struct {
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [15:0] pls;
    } vec_t;

    sb_t sbq[$];

    task automatic chk(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] flat(input int d);
        logic [511:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i*32 +: 32] = (i == 0) ? ID : model[d][i];
        end
        return r;
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 16; i++) model[d][i] = '0;
        end
    endtask

    // entered and left at posedge+1
    task automatic xfer(input int d, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic exp_err, input logic [15:0] exp_pls,
                        input bit keep, output int acc);
        sb_t e;
        sb_t got;
        e.d = d;
        e.rdata = exp_rd;
        e.err = exp_err;
        sbq.push_back(e);
        psel[d] = 1'b1;
        penable = 1'b0;
        pwrite  = w;
        paddr   = a;
        pwdata  = wd;
        @(posedge clk);
        #1 penable = 1'b1;
        acc = 0;
        while (1) begin
            @(negedge clk);
            acc++;
            if (pready[d] || acc > 40) break;
        end
        got = sbq.pop_front();
        if (!pready[d]) begin
            chk("pready_timeout", 512'(pready[d]), 512'(1));
        end else begin
            chk("prdata", 512'(prdata[got.d]), 512'(got.rdata));
            chk("pslverr", 512'(pslverr[got.d]), 512'(got.err));
        end
        @(posedge clk);
        #1 penable = 1'b0;
        if (!keep) psel[d] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (exp_pls[i]) model[d][i] = wd;
        end
        chk("regs_o", regs[d], flat(d));
        fork
            begin
                automatic int dd = d;
                automatic logic [15:0] ep = exp_pls;
                @(negedge clk);
                chk("wr_pulse", 512'(pulse[dd]), 512'(ep));
                @(negedge clk);
                chk("wr_pulse_clr", 512'(pulse[dd]), 512'(0));
            end
        join_none
    endtask

    // PRDATA and PSLVERR must stay low while PREADY is low
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!pready[d]) begin
                chk("idle_resp", 512'({prdata[d], pslverr[d]}), 512'(0));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [12];
        int acc;
        time t0;

        vt[0]  = '{1'b1, 32'h08, 32'hDEAD_BEEF, 32'h0, 1'b0, 16'h0004};
        vt[1]  = '{1'b0, 32'h08, 32'h0, 32'hDEAD_BEEF, 1'b0, 16'h0000};
        vt[2]  = '{1'b1, 32'h40, 32'h1111_1111, 32'h0, 1'b1, 16'h0000};
        vt[3]  = '{1'b1, 32'h06, 32'h2222_2222, 32'h0, 1'b1, 16'h0000};
        vt[4]  = '{1'b1, 32'h00, 32'h3333_3333, 32'h0, 1'b1, 16'h0000};
        vt[5]  = '{1'b0, 32'h00, 32'h0, ID, 1'b0, 16'h0000};
        vt[6]  = '{1'b0, 32'h3C, 32'h0, 32'h0, 1'b0, 16'h0000};
        vt[7]  = '{1'b1, 32'h3C, 32'h1234_5678, 32'h0, 1'b0, 16'h8000};
        vt[8]  = '{1'b0, 32'h3C, 32'h0, 32'h1234_5678, 1'b0, 16'h0000};
        vt[9]  = '{1'b0, 32'h41, 32'h0, 32'h0, 1'b1, 16'h0000};
        vt[10] = '{1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1, 16'h0000};
        vt[11] = '{1'b0, 32'h08, 32'h0, 32'hDEAD_BEEF, 1'b0, 16'h0000};

        clear_model();
        rst_n = 1'b0;
        paddr = '0;
        pwdata = '0;
        penable = 1'b0;
        pwrite = 1'b0;
        for (int d = 0; d < 3; d++) psel[d] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("rst_out", 512'({pready[d], prdata[d], pslverr[d], pulse[d]}),
                512'(0));
            chk("rst_regs", regs[d], flat(d));
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        // table: zero wait states, one access cycle each
        for (int i = 0; i < 12; i++) begin
            xfer(0, vt[i].w, vt[i].addr, vt[i].wdata, vt[i].rdata,
                 vt[i].err, vt[i].pls, 1'b0, acc);
            chk("acc_cyc_w0", 512'(acc), 512'(1));
        end

        // back-to-back writes with PSEL held: 2 cycles each
        t0 = $time;
        xfer(0, 1'b1, 32'h04, 32'h0000_0A04, 32'h0, 1'b0, 16'h0002, 1'b1, acc);
        xfer(0, 1'b1, 32'h08, 32'h0000_0A08, 32'h0, 1'b0, 16'h0004, 1'b1, acc);
        xfer(0, 1'b1, 32'h0C, 32'h0000_0A0C, 32'h0, 1'b0, 16'h0008, 1'b0, acc);
        chk("b2b_cycles", 512'(($time - t0) / 10), 512'(6));
        xfer(0, 1'b0, 32'h08, 32'h0, 32'h0000_0A08, 1'b0, 16'h0, 1'b0, acc);

        // three wait states: 4 access cycles, 5 in total
        xfer(2, 1'b0, 32'h00, 32'h0, ID, 1'b0, 16'h0, 1'b0, acc);
        chk("acc_cyc_w3", 512'(acc + 1), 512'(5));
        xfer(2, 1'b1, 32'h14, 32'h5555_AAAA, 32'h0, 1'b0, 16'h0020, 1'b0, acc);
        chk("acc_cyc_w3_wr", 512'(acc), 512'(4));
        xfer(2, 1'b0, 32'h14, 32'h0, 32'h5555_AAAA, 1'b0, 16'h0, 1'b0, acc);

        // abort: PSEL drops in the second access cycle
        psel[1] = 1'b1;
        pwrite  = 1'b1;
        paddr   = 32'h10;
        pwdata  = 32'hBAD0_BAD0;
        @(posedge clk);
        #1 penable = 1'b1;
        @(negedge clk);
        chk("abort_rdy1", 512'(pready[1]), 512'(0));
        @(posedge clk);
        #1;
        psel[1] = 1'b0;
        penable = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("abort_rdy", 512'({pready[1], pulse[1]}), 512'(0));
        end
        chk("abort_regs", regs[1], flat(1));
        @(posedge clk);
        #1;
        xfer(1, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 16'h0, 1'b0, acc);
        chk("acc_cyc_w2", 512'(acc), 512'(3));

        // reset in the middle of a write
        xfer(1, 1'b1, 32'h04, 32'hCAFE_0001, 32'h0, 1'b0, 16'h0002, 1'b0, acc);
        repeat (3) @(posedge clk);
        #1;
        psel[1] = 1'b1;
        pwrite  = 1'b1;
        paddr   = 32'h04;
        pwdata  = 32'h7777_7777;
        @(posedge clk);
        #1 penable = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        clear_model();
        chk("midrst_out",
            512'({pready[1], prdata[1], pslverr[1], pulse[1]}), 512'(0));
        chk("midrst_regs", regs[1], flat(1));
        @(posedge clk);
        #1;
        psel[1] = 1'b0;
        penable = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        xfer(1, 1'b0, 32'h04, 32'h0, 32'h0, 1'b0, 16'h0, 1'b0, acc);
        chk("post_rst_acc", 512'(acc), 512'(3));

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
